// File: rtl/zl_fifo_pkt_reader_pkg.sv
// Shared constants and state type for the FIFO packet reader.
// The transport-stream constants double as the reader's parameter defaults.
package zl_fifo_pkt_reader_pkg;

   localparam logic [7:0] TS_SYNC_WORD = 8'h47;
   localparam logic [7:0] TS_NULL_FILL = 8'hFF;
   localparam int         TS_PKT_LEN   = 188;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_NULL = 2'd2
   } state_t;

endpackage

// File: rtl/zl_fifo_pkt_reader.sv
// Drains a show-ahead FIFO into fixed-length packets, starting a packet only when
// a whole one is buffered, otherwise optionally emitting a null packet.
module zl_fifo_pkt_reader
   import zl_fifo_pkt_reader_pkg::*;
#(
   parameter int                    Data_width  = 8,
   parameter int                    Addr_width  = 10,
   parameter int                    Packet_len  = TS_PKT_LEN,
   parameter bit                    Null_enable = 1'b1,
   parameter logic [Data_width-1:0] Sync_word   = Data_width'(TS_SYNC_WORD),
   parameter logic [Data_width-1:0] Null_fill   = Data_width'(TS_NULL_FILL)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fifo_req,
   output logic                  fifo_ack,
   input  logic [Data_width-1:0] fifo_data,
   input  logic [Addr_width-1:0] fifo_used,
   input  logic                  fifo_full,
   output logic                  out_req,
   input  logic                  out_ack,
   output logic [Data_width-1:0] out_data,
   output logic                  out_sop,
   output logic                  out_eop,
   output logic                  out_null,
   output logic [15:0]           pkt_count,
   output logic [15:0]           null_count
);

   localparam int                    Cnt_width = (Packet_len > 1) ? $clog2(Packet_len) : 1;
   localparam logic [Cnt_width-1:0]  Last_idx  = Cnt_width'(Packet_len - 1);
   // One extra bit so a packet length of 2**Addr_width is representable; then only fifo_full can match.
   localparam logic [Addr_width:0]   Len_ext   = (Addr_width + 1)'(Packet_len);

   state_t                  state, state_nxt;
   logic [Cnt_width-1:0]    count;
   logic [15:0]             pkt_cnt_q, null_cnt_q;
   logic                    avail, last_word, xfer;
   logic                    req_c, ack_c, null_c;
   logic [Data_width-1:0]   data_c;

   assign avail     = fifo_full || ({1'b0, fifo_used} >= Len_ext);
   assign last_word = (count == Last_idx);

   always_comb begin
      state_nxt = state;
      req_c     = 1'b0;
      ack_c     = 1'b0;
      null_c    = 1'b0;
      data_c    = '0;
      case (state)
         ST_IDLE: begin
            if (avail) begin
               state_nxt = ST_DATA;
            end else if (Null_enable) begin
               state_nxt = ST_NULL;
            end
         end
         ST_DATA: begin
            req_c  = fifo_req;
            data_c = fifo_data;
            ack_c  = fifo_req && out_ack;
         end
         ST_NULL: begin
            req_c  = 1'b1;
            null_c = 1'b1;
            data_c = (count == '0) ? Sync_word : Null_fill;
         end
         default: state_nxt = ST_IDLE;
      endcase
      xfer = req_c && out_ack;
      if (xfer && last_word) begin
         state_nxt = ST_IDLE;
      end
   end

   // Outputs are forced low while reset is held so downstream sees nothing mid-abort.
   always_comb begin
      out_req    = rst_n && req_c;
      fifo_ack   = rst_n && ack_c;
      out_null   = rst_n && null_c;
      out_data   = rst_n ? data_c : '0;
      out_sop    = out_req && (count == '0);
      out_eop    = out_req && last_word;
      pkt_count  = rst_n ? pkt_cnt_q : 16'd0;
      null_count = rst_n ? null_cnt_q : 16'd0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         count      <= '0;
         pkt_cnt_q  <= 16'd0;
         null_cnt_q <= 16'd0;
      end else begin
         state <= state_nxt;
         if (xfer) begin
            count <= last_word ? '0 : count + 1'b1;
            if (last_word) begin
               if (state == ST_DATA) begin
                  pkt_cnt_q <= pkt_cnt_q + 16'd1;
               end else begin
                  null_cnt_q <= null_cnt_q + 16'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_zl_fifo_pkt_reader.sv
// Bench for zl_fifo_pkt_reader: a directed vector table, a randomized run against a
// packet-level reference model, and a small-FIFO instance for the wrap/full corner.
module tb_zl_fifo_pkt_reader;

   typedef struct {
      bit         rst_n;
      bit         ack;
      int         push;
      bit         req;
      logic [7:0] data;
      bit         sop;
      bit         eop;
      bit         nul;
      bit         fack;
      int         pkt;
      int         ncnt;
   } vec_t;

   logic        clk = 1'b0;

   logic        rst_a, ack_a, fifo_req_a, fifo_full_a, fifo_ack_a;
   logic [7:0]  fifo_data_a, out_data_a;
   logic [9:0]  fifo_used_a;
   logic        out_req_a, out_sop_a, out_eop_a, out_null_a;
   logic [15:0] pkt_a, null_a;

   logic        rst_b, ack_b, fifo_req_b, fifo_full_b, fifo_ack_b;
   logic [7:0]  fifo_data_b, out_data_b;
   logic [1:0]  fifo_used_b;
   logic        out_req_b, out_sop_b, out_eop_b, out_null_b;
   logic [15:0] pkt_b, null_b;

   logic [7:0]  qa[$];
   logic [7:0]  qb[$];
   logic [7:0]  ref_stream[$];
   vec_t        vecs[$];
   int          n_total = 0;
   int          n_pass  = 0;
   int          next_word = 1;

   always #5 clk = ~clk;

   zl_fifo_pkt_reader #(
      .Data_width(8), .Addr_width(10), .Packet_len(4), .Null_enable(1'b1)
   ) dut_a (
      .clk(clk), .rst_n(rst_a),
      .fifo_req(fifo_req_a), .fifo_ack(fifo_ack_a), .fifo_data(fifo_data_a),
      .fifo_used(fifo_used_a), .fifo_full(fifo_full_a),
      .out_req(out_req_a), .out_ack(ack_a), .out_data(out_data_a),
      .out_sop(out_sop_a), .out_eop(out_eop_a), .out_null(out_null_a),
      .pkt_count(pkt_a), .null_count(null_a)
   );

   zl_fifo_pkt_reader #(
      .Data_width(8), .Addr_width(2), .Packet_len(4), .Null_enable(1'b0)
   ) dut_b (
      .clk(clk), .rst_n(rst_b),
      .fifo_req(fifo_req_b), .fifo_ack(fifo_ack_b), .fifo_data(fifo_data_b),
      .fifo_used(fifo_used_b), .fifo_full(fifo_full_b),
      .out_req(out_req_b), .out_ack(ack_b), .out_data(out_data_b),
      .out_sop(out_sop_b), .out_eop(out_eop_b), .out_null(out_null_b),
      .pkt_count(pkt_b), .null_count(null_b)
   );

   function automatic vec_t mk(bit r, bit k, int p, bit q, logic [7:0] d, bit s, bit e,
                               bit n, bit f, int pc, int nc);
      vec_t v;
      v.rst_n = r; v.ack = k; v.push = p; v.req = q; v.data = d; v.sop = s;
      v.eop = e; v.nul = n; v.fack = f; v.pkt = pc; v.ncnt = nc;
      return v;
   endfunction

   task automatic checkOutput(string name, int actual, int expected);
      n_total++;
      if (actual == expected) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
      end
   endtask

   // The bench FIFOs are plain queues; outputs mirror their head and fill level.
   task automatic refreshFifo();
      fifo_req_a  = (qa.size() != 0);
      fifo_data_a = (qa.size() != 0) ? qa[0] : 8'h00;
      fifo_used_a = 10'(qa.size());
      fifo_full_a = (qa.size() >= 1024);
      fifo_req_b  = (qb.size() != 0);
      fifo_data_b = (qb.size() != 0) ? qb[0] : 8'h00;
      fifo_used_b = 2'(qb.size());
      fifo_full_b = (qb.size() >= 4);
   endtask

   // Called after the mid-cycle sample: pops whatever the DUTs acked, lands just after the edge.
   task automatic step();
      bit pop_a, pop_b;
      pop_a = fifo_ack_a;
      pop_b = fifo_ack_b;
      @(posedge clk);
      #1;
      if (pop_a && qa.size() != 0) void'(qa.pop_front());
      if (pop_b && qb.size() != 0) void'(qb.pop_front());
      refreshFifo();
   endtask

   task automatic applyStimulus(vec_t v);
      rst_a = v.rst_n;
      ack_a = v.ack;
      for (int i = 0; i < v.push; i++) begin
         qa.push_back(8'(next_word));
         next_word++;
      end
      refreshFifo();
   endtask

   task automatic checkA(string tag, bit req, logic [7:0] data, bit sop, bit eop, bit nul,
                         bit fack, int pc, int nc);
      checkOutput({tag, " out_req"},    int'(out_req_a),  int'(req));
      checkOutput({tag, " out_data"},   int'(out_data_a), int'(data));
      checkOutput({tag, " out_sop"},    int'(out_sop_a),  int'(sop));
      checkOutput({tag, " out_eop"},    int'(out_eop_a),  int'(eop));
      checkOutput({tag, " out_null"},   int'(out_null_a), int'(nul));
      checkOutput({tag, " fifo_ack"},   int'(fifo_ack_a), int'(fack));
      checkOutput({tag, " pkt_count"},  int'(pkt_a),      pc);
      checkOutput({tag, " null_count"}, int'(null_a),     nc);
   endtask

   initial begin
      bit         busy, is_null;
      int         idx, m_pkt, m_null;
      logic [7:0] w;

      rst_a = 1'b0; ack_a = 1'b0; rst_b = 1'b0; ack_b = 1'b0;
      refreshFifo();
      repeat (2) begin
         @(negedge clk);
         step();
      end

      // Cycle-by-cycle expectations for packet length 4: data packet, null packet,
      // backpressured data packet, then a reset in the middle of a packet.
      vecs.push_back(mk(0,1,5, 0,8'h00,0,0,0,0, 0,0));
      vecs.push_back(mk(0,1,0, 0,8'h00,0,0,0,0, 0,0));
      vecs.push_back(mk(1,1,0, 0,8'h00,0,0,0,0, 0,0));
      vecs.push_back(mk(1,1,0, 1,8'h01,1,0,0,1, 0,0));
      vecs.push_back(mk(1,1,0, 1,8'h02,0,0,0,1, 0,0));
      vecs.push_back(mk(1,1,0, 1,8'h03,0,0,0,1, 0,0));
      vecs.push_back(mk(1,1,2, 1,8'h04,0,1,0,1, 0,0));
      vecs.push_back(mk(1,1,0, 0,8'h00,0,0,0,0, 1,0));
      vecs.push_back(mk(1,1,0, 1,8'h47,1,0,1,0, 1,0));
      vecs.push_back(mk(1,1,0, 1,8'hFF,0,0,1,0, 1,0));
      vecs.push_back(mk(1,1,0, 1,8'hFF,0,0,1,0, 1,0));
      vecs.push_back(mk(1,1,0, 1,8'hFF,0,1,1,0, 1,0));
      vecs.push_back(mk(1,1,1, 0,8'h00,0,0,0,0, 1,1));
      vecs.push_back(mk(1,1,0, 1,8'h05,1,0,0,1, 1,1));
      vecs.push_back(mk(1,0,0, 1,8'h06,0,0,0,0, 1,1));
      vecs.push_back(mk(1,0,0, 1,8'h06,0,0,0,0, 1,1));
      vecs.push_back(mk(1,1,0, 1,8'h06,0,0,0,1, 1,1));
      vecs.push_back(mk(1,0,0, 1,8'h07,0,0,0,0, 1,1));
      vecs.push_back(mk(1,0,0, 1,8'h07,0,0,0,0, 1,1));
      vecs.push_back(mk(1,1,0, 1,8'h07,0,0,0,1, 1,1));
      vecs.push_back(mk(1,0,0, 1,8'h08,0,1,0,0, 1,1));
      vecs.push_back(mk(1,1,0, 1,8'h08,0,1,0,1, 1,1));
      vecs.push_back(mk(1,1,4, 0,8'h00,0,0,0,0, 2,1));
      vecs.push_back(mk(1,1,0, 1,8'h09,1,0,0,1, 2,1));
      vecs.push_back(mk(0,1,1, 0,8'h00,0,0,0,0, 0,0));
      vecs.push_back(mk(1,1,0, 0,8'h00,0,0,0,0, 0,0));
      vecs.push_back(mk(1,1,0, 1,8'h0A,1,0,0,1, 0,0));
      vecs.push_back(mk(1,1,0, 1,8'h0B,0,0,0,1, 0,0));
      vecs.push_back(mk(1,1,0, 1,8'h0C,0,0,0,1, 0,0));
      vecs.push_back(mk(1,1,0, 1,8'h0D,0,1,0,1, 0,0));
      vecs.push_back(mk(1,1,0, 0,8'h00,0,0,0,0, 1,0));
      vecs.push_back(mk(1,1,0, 1,8'h47,1,0,1,0, 1,0));

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         @(negedge clk);
         checkA($sformatf("vec%0d", i), vecs[i].req, vecs[i].data, vecs[i].sop, vecs[i].eop,
                vecs[i].nul, vecs[i].fack, vecs[i].pkt, vecs[i].ncnt);
         step();
      end
      checkOutput("fifo depth after table", qa.size(), 0);

      // Randomized run: the model tracks packets at word level from the pushed stream.
      rst_a = 1'b0;
      qa.delete();
      refreshFifo();
      repeat (2) begin
         @(negedge clk);
         step();
      end
      rst_a = 1'b1;
      busy = 1'b0; is_null = 1'b0; idx = 0; m_pkt = 0; m_null = 0;
      for (int c = 0; c < 1500; c++) begin
         ack_a = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 2) == 0 && qa.size() < 900) begin
            w = 8'($urandom);
            qa.push_back(w);
            ref_stream.push_back(w);
         end
         refreshFifo();
         @(negedge clk);
         if (!busy) begin
            checkA("rand idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, m_pkt & 16'hFFFF, m_null & 16'hFFFF);
            is_null = (ref_stream.size() < 4);
            busy = 1'b1;
            idx = 0;
         end else begin
            if (is_null) w = (idx == 0) ? 8'h47 : 8'hFF;
            else         w = ref_stream[0];
            checkA("rand pkt", 1'b1, w, idx == 0, idx == 3, is_null, ack_a && !is_null,
                   m_pkt & 16'hFFFF, m_null & 16'hFFFF);
            if (ack_a) begin
               if (!is_null) void'(ref_stream.pop_front());
               idx++;
               if (idx == 4) begin
                  busy = 1'b0;
                  if (is_null) m_null++;
                  else         m_pkt++;
               end
            end
         end
         step();
      end
      ack_a = 1'b0;

      // Small FIFO with nulls disabled: 3 words wait, the 4th fills it (used wraps to 0).
      for (int i = 0; i < 3; i++) qb.push_back(8'(101 + i));
      refreshFifo();
      @(negedge clk);
      checkOutput("B reset out_req", int'(out_req_b), 0);
      step();
      rst_b = 1'b1;
      ack_b = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("B underfilled out_req", int'(out_req_b), 0);
         checkOutput("B underfilled out_null", int'(out_null_b), 0);
         step();
      end
      qb.push_back(8'd104);
      refreshFifo();
      @(negedge clk);
      checkOutput("B full used", int'(fifo_used_b), 0);
      checkOutput("B bubble out_req", int'(out_req_b), 0);
      step();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("B out_req",  int'(out_req_b),  1);
         checkOutput("B out_data", int'(out_data_b), 101 + i);
         checkOutput("B out_sop",  int'(out_sop_b),  int'(i == 0));
         checkOutput("B out_eop",  int'(out_eop_b),  int'(i == 3));
         checkOutput("B out_null", int'(out_null_b), 0);
         checkOutput("B fifo_ack", int'(fifo_ack_b), 1);
         step();
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("B empty out_req", int'(out_req_b), 0);
         step();
      end
      checkOutput("B pkt_count",  int'(pkt_b),  1);
      checkOutput("B null_count", int'(null_b), 0);
      checkOutput("B fifo depth", qb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
